// File: rtl/amp_pwr_seq.sv
// Power sequencer and fault manager for NUM_AMP class-D amplifiers.
// Optional staggered amp release: define AMP_PWR_STAGGER_EN.
module amp_pwr_seq #(
  parameter int NUM_AMP     = 2,
  parameter int PWRUP_CYC   = 250000,
  parameter int MUTE_CYC    = 25000,
  parameter int FLT_FILT    = 4,
  parameter int RETRY_CYC   = 1000000,
  parameter int MAX_RETRY   = 3,
  parameter int STAGGER_CYC = 5000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [NUM_AMP-1:0]               Flt_n,
  input  logic                             clr_flt,
  output logic [NUM_AMP-1:0]               sht_dwn,
  output logic                             mute,
  output logic [NUM_AMP-1:0]               flt_latched,
  output logic                             locked,
  output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt,
  output logic                             pwr_good
);

`ifdef AMP_PWR_STAGGER_EN
  localparam int REL_STEP = STAGGER_CYC;
`else
  // All amps release together, so the step between releases is zero.
  localparam int REL_STEP = STAGGER_CYC * 0;
`endif

  localparam int RW       = $clog2(MAX_RETRY+1);
  localparam int FW       = $clog2(FLT_FILT+1);
  localparam int REL_END  = (NUM_AMP-1) * REL_STEP;
  localparam int MUTE_END = REL_END + MUTE_CYC;
  localparam int TMAX0    = (PWRUP_CYC > RETRY_CYC) ? PWRUP_CYC : RETRY_CYC;
  localparam int TMAX     = (TMAX0 > MUTE_END) ? TMAX0 : MUTE_END;
  localparam int TW       = $clog2(TMAX+1);

  localparam logic [TW-1:0] T_PWR   = TW'(PWRUP_CYC-1);
  localparam logic [TW-1:0] T_RETRY = TW'(RETRY_CYC-1);
  localparam logic [TW-1:0] T_MUTE  = TW'(MUTE_END);
  localparam logic [TW-1:0] T_SAT   = TW'(TMAX);
  localparam logic [FW-1:0] F_THR   = FW'(FLT_FILT);
  localparam logic [RW-1:0] R_MAX   = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    PWRUP   = 3'd1,
    RUN     = 3'd2,
    FAULT   = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  state_t state, state_n;

  logic [NUM_AMP-1:0] sync1, sync2;
  logic [FW-1:0]      fcnt [NUM_AMP];
  logic [NUM_AMP-1:0] flt;
  logic [TW-1:0]      timer;
  logic               tmr_clr;
  logic               fault_set;
  logic               retry_clr;
  logic               any_flt;

  // Two-flop synchronizer; idles high (no fault) out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= Flt_n;
      sync2 <= sync1;
    end
  end

  // Saturating low-run counters; any high sample restarts the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_AMP; i++) fcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_AMP; i++) begin
        if (sync2[i])
          fcnt[i] <= '0;
        else if (fcnt[i] != F_THR)
          fcnt[i] <= fcnt[i] + 1'b1;
      end
    end
  end

  // Filtered fault flags.
  always_comb begin
    flt = '0;
    for (int i = 0; i < NUM_AMP; i++) flt[i] = (fcnt[i] == F_THR);
  end

  assign any_flt = |flt;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= OFF;
    else     state <= state_n;
  end

  // Next-state logic; a fault beats en=0 in the powered states.
  always_comb begin
    state_n   = state;
    tmr_clr   = 1'b0;
    fault_set = 1'b0;
    retry_clr = 1'b0;
    unique case (state)
      OFF: begin
        if (en) state_n = PWRUP;
      end
      PWRUP: begin
        if (any_flt) begin
          state_n   = FAULT;
          fault_set = 1'b1;
        end else if (!en) begin
          state_n   = OFF;
          retry_clr = 1'b1;
        end else if (timer == T_PWR) begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (any_flt) begin
          state_n   = FAULT;
          fault_set = 1'b1;
        end else if (!en) begin
          state_n   = OFF;
          retry_clr = 1'b1;
        end
      end
      FAULT: begin
        if (!en) begin
          state_n   = OFF;
          retry_clr = 1'b1;
        end else if (timer == T_RETRY) begin
          if (retry_cnt == R_MAX)
            state_n = LOCKOUT;
          else if (!any_flt)
            state_n = PWRUP;
          else
            tmr_clr = 1'b1;
        end
      end
      LOCKOUT: begin
        if (clr_flt) begin
          state_n   = OFF;
          retry_clr = 1'b1;
        end
      end
      default: state_n = OFF;
    endcase
    if (state_n != state) tmr_clr = 1'b1;
  end

  // Shared timer: restarts on every transition, saturates at its top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                timer <= '0;
    else if (tmr_clr)       timer <= '0;
    else if (timer != T_SAT) timer <= timer + 1'b1;
  end

  // Sticky fault record; a newly latched bit survives a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      flt_latched <= '0;
    else
      flt_latched <= (clr_flt ? '0 : flt_latched) |
                     (fault_set ? flt : '0);
  end

  // Fault counter, saturating at the lockout threshold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      retry_cnt <= '0;
    else if (retry_clr)
      retry_cnt <= '0;
    else if (fault_set && retry_cnt != R_MAX)
      retry_cnt <= retry_cnt + 1'b1;
  end

  // Outputs decoded from state and timer.
  always_comb begin
    sht_dwn  = '1;
    mute     = 1'b1;
    pwr_good = 1'b0;
    locked   = (state == LOCKOUT);
    if (state == RUN) begin
      for (int i = 0; i < NUM_AMP; i++) begin
`ifdef AMP_PWR_STAGGER_EN
        sht_dwn[i] = (timer < TW'(i * REL_STEP));
`else
        sht_dwn[i] = 1'b0;
`endif
      end
      mute     = (timer < T_MUTE);
      pwr_good = !mute;
    end
  end

endmodule

// File: tb/tb_amp_pwr_seq.sv
// Directed bench for amp_pwr_seq with short test timings.
// Stagger checks follow AMP_PWR_STAGGER_EN.
module tb_amp_pwr_seq;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] Flt_n;
  logic       clr_flt;
  logic [1:0] sht_dwn;
  logic       mute;
  logic [1:0] flt_latched;
  logic       locked;
  logic [1:0] retry_cnt;
  logic       pwr_good;

  int vectors;
  int miscompares;

  amp_pwr_seq #(
    .NUM_AMP(2), .PWRUP_CYC(100), .MUTE_CYC(20), .FLT_FILT(4),
    .RETRY_CYC(50), .MAX_RETRY(2), .STAGGER_CYC(10)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .Flt_n(Flt_n), .clr_flt(clr_flt),
    .sht_dwn(sht_dwn), .mute(mute), .flt_latched(flt_latched),
    .locked(locked), .retry_cnt(retry_cnt), .pwr_good(pwr_good)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pg(input string tag, input int limit);
    for (int i = 0; i < limit && pwr_good !== 1'b1; i++) tick(1);
    chk(tag, 32'(pwr_good), 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sht"}, 32'(sht_dwn), 32'd3);
    chk({tag, "_mute"}, 32'(mute), 32'd1);
    chk({tag, "_fltl"}, 32'(flt_latched), 32'd0);
    chk({tag, "_lock"}, 32'(locked), 32'd0);
    chk({tag, "_retry"}, 32'(retry_cnt), 32'd0);
    chk({tag, "_pg"}, 32'(pwr_good), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst     = 1'b1;
    en      = 1'b0;
    Flt_n   = 2'b11;
    clr_flt = 1'b0;
    tick(2);
    chk_reset("rst");

    // Power-up timing from en at cycle 0.
    rst = 1'b0;
    en  = 1'b1;
    tick(1);
    chk("c1_sht", 32'(sht_dwn), 32'd3);
    chk("c1_mute", 32'(mute), 32'd1);
    tick(99);
    chk("c100_sht", 32'(sht_dwn), 32'd3);
    tick(1);
`ifdef AMP_PWR_STAGGER_EN
    chk("c101_sht", 32'(sht_dwn), 32'd2);
    tick(9);
    chk("c110_sht", 32'(sht_dwn), 32'd2);
    tick(1);
    chk("c111_sht", 32'(sht_dwn), 32'd0);
    chk("c111_mute", 32'(mute), 32'd1);
    tick(19);
    chk("c130_mute", 32'(mute), 32'd1);
    tick(1);
    chk("c131_mute", 32'(mute), 32'd0);
    chk("c131_pg", 32'(pwr_good), 32'd1);
`else
    chk("c101_sht", 32'(sht_dwn), 32'd0);
    chk("c101_mute", 32'(mute), 32'd1);
    chk("c101_pg", 32'(pwr_good), 32'd0);
    tick(19);
    chk("c120_mute", 32'(mute), 32'd1);
    tick(1);
    chk("c121_mute", 32'(mute), 32'd0);
    chk("c121_pg", 32'(pwr_good), 32'd1);
`endif

    // 3-cycle glitch on amp 1 is filtered out.
    Flt_n = 2'b01;
    tick(3);
    Flt_n = 2'b11;
    tick(10);
    chk("glitch_sht", 32'(sht_dwn), 32'd0);
    chk("glitch_fltl", 32'(flt_latched), 32'd0);
    chk("glitch_pg", 32'(pwr_good), 32'd1);

    // Sustained fault on amp 1: FAULT 7 cycles after the pin falls.
    Flt_n = 2'b01;
    tick(6);
    chk("f1_c6_pg", 32'(pwr_good), 32'd1);
    tick(1);
    chk("f1_sht", 32'(sht_dwn), 32'd3);
    chk("f1_mute", 32'(mute), 32'd1);
    chk("f1_pg", 32'(pwr_good), 32'd0);
    chk("f1_fltl", 32'(flt_latched), 32'd2);
    chk("f1_retry", 32'(retry_cnt), 32'd1);
    Flt_n = 2'b11;
    // Retry to PWRUP at +50, then RUN 100 cycles later.
    tick(149);
    chk("f1_c149_sht0", 32'(sht_dwn[0]), 32'd1);
    tick(1);
    chk("f1_c150_sht0", 32'(sht_dwn[0]), 32'd0);
    wait_pg("f1_pg_back", 100);

    // Second sustained fault reaches the retry limit.
    Flt_n = 2'b10;
    tick(7);
    chk("f2_sht", 32'(sht_dwn), 32'd3);
    chk("f2_fltl", 32'(flt_latched), 32'd3);
    chk("f2_retry", 32'(retry_cnt), 32'd2);
    tick(49);
    chk("f2_c49_lock", 32'(locked), 32'd0);
    tick(1);
    chk("f2_c50_lock", 32'(locked), 32'd1);
    chk("f2_c50_sht", 32'(sht_dwn), 32'd3);
    Flt_n = 2'b11;
    en    = 1'b0;
    tick(5);
    chk("lock_en0", 32'(locked), 32'd1);
    chk("lock_en0_retry", 32'(retry_cnt), 32'd2);
    en = 1'b1;
    tick(5);
    chk("lock_en1", 32'(locked), 32'd1);
    chk("lock_en1_sht", 32'(sht_dwn), 32'd3);
    clr_flt = 1'b1;
    tick(1);
    clr_flt = 1'b0;
    chk("clr_lock", 32'(locked), 32'd0);
    chk("clr_retry", 32'(retry_cnt), 32'd0);
    chk("clr_fltl", 32'(flt_latched), 32'd0);
    wait_pg("clr_pg_back", 300);

    // en=0 on the same cycle the fault is accepted: fault wins.
    Flt_n = 2'b10;
    tick(6);
    chk("race_pg", 32'(pwr_good), 32'd1);
    en = 1'b0;
    tick(1);
    chk("race_retry", 32'(retry_cnt), 32'd1);
    chk("race_fltl", 32'(flt_latched), 32'd1);
    chk("race_sht", 32'(sht_dwn), 32'd3);
    tick(1);
    chk("off_retry", 32'(retry_cnt), 32'd0);
    chk("off_fltl", 32'(flt_latched), 32'd1);
    Flt_n   = 2'b11;
    clr_flt = 1'b1;
    tick(1);
    clr_flt = 1'b0;
    chk("clr_off_fltl", 32'(flt_latched), 32'd0);

    // Async reset in the middle of a retry power-up.
    tick(3);
    en = 1'b1;
    wait_pg("r_pg", 300);
    Flt_n = 2'b01;
    tick(7);
    chk("r_fltl", 32'(flt_latched), 32'd2);
    chk("r_retry", 32'(retry_cnt), 32'd1);
    Flt_n = 2'b11;
    tick(70);
    chk("r_pwrup_sht", 32'(sht_dwn), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    tick(1);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
